// File: rtl/bcd_to_binary.sv
// Purpose: converts three BCD digits (0-999) to a 10-bit binary value using reverse double-dabble.
// Latency: 10 cycles from the start capture edge to the done pulse; one conversion per 11 cycles.
// Backpressure: start is honoured only in IDLE and ignored while busy; an invalid digit is rejected with done+err.
module bcd_to_binary (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] cientos,
    input  logic [3:0] dieces,
    input  logic [3:0] unos,
    output logic [9:0] binario,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Correction applied to each BCD field after the shift: a field that
    // received a carry-in bit from the field above reads >= 8 and must drop by 3.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] field);
        return (field >= 4'd8) ? (field - 4'd3) : field;
    endfunction

    state_t      state_q, state_d;
    logic [21:0] work_q, work_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  binario_d;
    logic        done_d;
    logic        err_d;

    logic [21:0] shifted;
    logic [21:0] stepped;
    logic        digits_ok;

    assign busy = (state_q == SHIFT);

    // One iteration of the datapath: shift right with zero fill, then fix up each BCD field.
    always_comb begin
        shifted   = {1'b0, work_q[21:1]};
        stepped   = {bcd_adjust(shifted[21:18]),
                     bcd_adjust(shifted[17:14]),
                     bcd_adjust(shifted[13:10]),
                     shifted[9:0]};
        digits_ok = (cientos <= 4'd9) && (dieces <= 4'd9) && (unos <= 4'd9);
    end

    // Next-state and output logic; done/err are registered so they pulse one cycle after the deciding edge.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        binario_d = binario;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (digits_ok) begin
                        work_d  = {cientos, dieces, unos, 10'd0};
                        cnt_d   = 4'd0;
                        state_d = SHIFT;
                    end else begin
                        // Rejected request: report it but leave the previous result intact.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d = stepped;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    binario_d = stepped[9:0];
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 22'd0;
            cnt_q   <= 4'd0;
            binario <= 10'd0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            binario <= binario_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Purpose: scoreboard bench for bcd_to_binary; stimulus pushes expected results, a monitor pops on done.
// Latency: expects done 10 cycles after a valid capture, 1 cycle after a rejected one.
// Backpressure: stimulus waits for each done before issuing the next request (except the held-start case).
module tb_bcd_to_binary;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] cientos;
    logic [3:0] dieces;
    logic [3:0] unos;
    logic [9:0] binario;
    logic       busy;
    logic       done;
    logic       err;

    int tests;
    int fails;
    int cyc;
    int busy_run;

    // Expected response entries: {err, value}.
    logic [10:0] exp_q[$];
    logic [9:0]  model_prev;

    bcd_to_binary dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cientos (cientos),
        .dieces  (dieces),
        .unos    (unos),
        .binario (binario),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for measuring spacing between done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        logic [10:0] e;
        int          exp_run;
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run = busy_run + 1;
            if (done) begin
                tests = tests + 1;
                if (exp_q.size() == 0) begin
                    fails = fails + 1;
                    $display("FAIL unexpected_done: got done with binario=%0d err=%0b, required no done", binario, err);
                end else begin
                    e       = exp_q.pop_front();
                    exp_run = e[10] ? 0 : 10;
                    if (binario !== e[9:0] || err !== e[10] || busy_run != exp_run) begin
                        fails = fails + 1;
                        $display("FAIL result: got binario=%0d err=%0b busy_cycles=%0d, required binario=%0d err=%0b busy_cycles=%0d",
                                 binario, err, busy_run, e[9:0], e[10], exp_run);
                    end
                end
                busy_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests = tests + 1;
        if (got != want) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Reference model: plain decimal arithmetic, rejected codes keep the previous result.
    task automatic model_push(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
        if (c > 9 || d > 9 || u > 9) begin
            exp_q.push_back({1'b1, model_prev});
        end else begin
            model_prev = 10'(100 * int'(c) + 10 * int'(d) + int'(u));
            exp_q.push_back({1'b0, model_prev});
        end
    endtask

    // Issue one request in the current (IDLE) cycle; it is captured at the next edge.
    task automatic issue(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
        cientos = c;
        dieces  = d;
        unos    = u;
        start   = 1'b1;
        model_push(c, d, u);
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) until done is visible.
    task automatic wait_done();
        int i;
        for (i = 0; i < 20; i++) begin
            if (done) break;
            tick();
        end
        if (!done) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL done_timeout: got no done within 20 cycles, required a done pulse");
        end
    endtask

    task automatic run_conv(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
        issue(c, d, u);
        wait_done();
    endtask

    initial begin
        int t1;
        int t2;
        tests      = 0;
        fails      = 0;
        cyc        = 0;
        busy_run   = 0;
        model_prev = 10'd0;
        rst_n      = 1'b0;
        start      = 1'b0;
        cientos    = 4'd0;
        dieces     = 4'd0;
        unos       = 4'd0;
        tick();
        tick();
        check("reset_binario", int'(binario), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        rst_n = 1'b1;
        tick();

        // Directed cases.
        run_conv(4'd9, 4'd9, 4'd9);
        run_conv(4'd0, 4'd0, 4'd0);
        run_conv(4'd2, 4'd5, 4'd5);
        run_conv(4'd1, 4'd2, 4'd8);
        tick();
        run_conv(4'd1, 4'hA, 4'd3);
        tick();
        check("err_no_busy", int'(busy), 0);
        check("err_hold_binario", int'(binario), 128);

        // Start toggling and digit changes during a conversion must be ignored.
        issue(4'd5, 4'd0, 4'd0);
        for (int k = 0; k < 10; k++) begin
            start   = (k % 2 == 0);
            cientos = 4'd7;
            dieces  = 4'd7;
            unos    = 4'd7;
            tick();
        end
        start = 1'b0;
        wait_done();
        check("toggle_binario", int'(binario), 500);
        for (int k = 0; k < 15; k++) tick();

        // Reset in the middle of a conversion aborts it with no done afterwards.
        cientos = 4'd3;
        dieces  = 4'd4;
        unos    = 4'd5;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_binario", int'(binario), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_err", int'(err), 0);
        model_prev = 10'd0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        run_conv(4'd0, 4'd4, 4'd2);
        tick();

        // Start held continuously: second request captured in the first done cycle.
        cientos = 4'd6;
        dieces  = 4'd7;
        unos    = 4'd8;
        start   = 1'b1;
        model_push(4'd6, 4'd7, 4'd8);
        tick();
        cientos = 4'd0;
        dieces  = 4'd0;
        unos    = 4'd1;
        model_push(4'd0, 4'd0, 4'd1);
        wait_done();
        t1 = cyc;
        check("b2b_first", int'(binario), 678);
        tick();
        start = 1'b0;
        wait_done();
        t2 = cyc;
        check("b2b_second", int'(binario), 1);
        check("b2b_spacing", t2 - t1, 11);
        tick();

        // Exhaustive sweep of all valid codes.
        for (int c = 0; c < 10; c++)
            for (int d = 0; d < 10; d++)
                for (int u = 0; u < 10; u++)
                    run_conv(4'(c), 4'(d), 4'(u));

        // Random codes, including out-of-range digits.
        for (int k = 0; k < 200; k++) begin
            run_conv(4'($urandom_range(0, 15)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 10)));
            if ($urandom_range(0, 3) == 0) tick();
        end

        for (int k = 0; k < 15; k++) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential three-digit BCD-to-binary converter using the reverse double-dabble algorithm: shift right, subtract 3 from any digit ≥ 8.
- Sits on the display/keypad side of the sequential multiplier datapath.
- Turns operator-entered decimal digits (0–999) into the 10-bit binary operand consumed by the multiplier.
- Complements the existing binary-to-BCD display path.
- Handshake: start/busy/done, fixed 10-cycle latency.

## Interface
- No parameters; width is fixed at 3 BCD digits in, 10 bits out.
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  conversion request, sampled only in IDLE
- cientos  input  4  hundreds digit, valid range 0–9
- dieces  input  4  tens digit, valid range 0–9
- unos  input  4  units digit, valid range 0–9
- binario  output  10  converted value 0–999, held until next successful conversion
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse, conversion finished or rejected
- err  output  1  one-cycle pulse coincident with done, input digit > 9

## Operation
- Working register: 22 bits = {bcd[11:0], bin[9:0]}.
  - bcd = {cientos, dieces, unos} captured at start.
  - bin starts at 0.
  - Iteration counter: 4 bits.
- States: IDLE, SHIFT.
- IDLE, start=1, all digits ≤ 9:
  - load working register, clear counter, go to SHIFT, busy=1.
- IDLE, start=1, any digit > 9:
  - stay in IDLE; next cycle done=1 and err=1.
  - binario unchanged, busy stays 0.
- SHIFT, one iteration per cycle:
  - shift the full 22-bit register right by 1, zero-fill the MSB.
  - for each of the three 4-bit BCD fields: if the field is ≥ 8, subtract 3.
  - increment the counter.
- After the 10th iteration:
  - binario <= bin[9:0] (the post-iteration value).
  - done=1 for one cycle, busy=0, return to IDLE.
- start during SHIFT is ignored; inputs may change freely after the capture edge.
- err is never asserted on a valid conversion.

## Timing
- Reset (async assert, any state): IDLE, binario=0, busy=0, done=0, err=0, working register and counter cleared.
- Reset mid-conversion aborts; no done pulse follows deassertion.
- Start captured at edge N. busy is high from after edge N to after edge N+10.
- Iterations occur at edges N+1 … N+10. binario updates and done rises after edge N+10.
- done/err fall after the next edge.
- The done cycle is IDLE, so start may be asserted there. That start is captured at edge N+11, and busy rises again with no idle gap beyond the done cycle.
- Throughput: one conversion per 11 cycles.
- Invalid-digit start at edge N: done=err=1 in the cycle after edge N only.

## Test plan
- Reset, then digits 9,9,9 with start pulse:
  - busy high 10 cycles, then done pulse with binario=999 (0x3E7), err=0.
- Digits 0,0,0:
  - binario=0 after 10 cycles.
  - Follow with 2,5,5 → binario=255.
  - Then 1,2,8 → binario=128.
- Digits 1,10,3 (tens digit 0xA) with start:
  - done=err=1 for one cycle, busy never rises, binario retains the previous value.
- During conversion of 5,0,0:
  - toggle start and change digits to 7,7,7 each cycle.
  - Result is binario=500, and exactly one done pulse.
- Start with 3,4,5, then assert rst_n=0 at iteration 5:
  - all outputs immediately 0, no done pulse afterwards.
  - A fresh start with 0,4,2 gives binario=42.
- Back-to-back: start held high continuously with 6,7,8 then 0,0,1:
  - done every 11 cycles, binario sequence 678 then 1.
- Exhaustive sweep of all 1000 valid codes:
  - each result equals 100·cientos + 10·dieces + unos.
